multicycle_ctrl_seq: RTL and testbench

- Parametrised multicycle MIPS control sequencer. It steps one instruction at a time through IF/ID/EX/MEM/WB phases, or terminates early on BR/JU, with the path chosen by the opcode class.
- Generalises the fixed phase rotator:
  - per-opcode phase skipping
  - configurable multi-cycle MEM phase
  - drain-on-disable
  - retired-instruction counter
  - illegal-opcode flag
- Sits between the top-level enable and the datapath stage enables.

---
 rtl/multicycle_ctrl_seq.sv | 127 ++++++++++++
 tb/tb_multicycle_ctrl_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_seq.sv
// Multicycle MIPS control sequencer: walks each instruction through its opcode-selected
// phase path, holds MEM for MEM_LAT cycles, drains on disable and counts retired instructions.
module multicycle_ctrl_seq #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             top_en,
  input  logic [OP_W-1:0]  opcode,
  output logic             IF,
  output logic             ID,
  output logic             EX,
  output logic             MEM,
  output logic             WB,
  output logic             BR,
  output logic             JU,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
    S_MEM  = 3'd4, S_WB = 3'd5, S_BR = 3'd6, S_JU = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU = 3'd0, C_LW = 3'd1, C_SW = 3'd2, C_BR = 3'd3, C_JU = 3'd4, C_ILL = 3'd5
  } cls_t;

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_t     state;
  cls_t       cls;
  logic [3:0] mem_cnt;
  cls_t       dec_s;
  logic       mem_last_s;
  logic       final_s;

  function automatic cls_t decode_op(input logic [OP_W-1:0] op);
    cls_t c;
    case (op)
      OP_W'(6'b000000), OP_W'(6'b001000): c = C_ALU;
      OP_W'(6'b100011):                   c = C_LW;
      OP_W'(6'b101011):                   c = C_SW;
      OP_W'(6'b000100):                   c = C_BR;
      OP_W'(6'b000010):                   c = C_JU;
      default:                            c = C_ILL;
    endcase
    return c;
  endfunction

  assign dec_s      = decode_op(opcode);
  assign mem_last_s = (mem_cnt == MEM_LAST);

  // Final-phase detection: the cycle in which the current instruction retires.
  always_comb begin
    final_s = 1'b0;
    case (state)
      S_WB, S_BR, S_JU: final_s = 1'b1;
      S_MEM:            final_s = (cls == C_SW) && mem_last_s;
      S_ID:             final_s = (dec_s == C_ILL);
      default:          final_s = 1'b0;
    endcase
  end

  // Sequencer state, latched class, MEM hold counter and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cls     <= C_ALU;
      mem_cnt <= 4'd0;
      retired <= '0;
    end else if (final_s) begin
      retired <= retired + CNT_W'(1);
      state   <= top_en ? S_IF : S_IDLE;
    end else begin
      case (state)
        S_IDLE: state <= top_en ? S_IF : S_IDLE;
        S_IF:   state <= S_ID;
        S_ID: begin
          cls <= dec_s;
          case (dec_s)
            C_BR:    state <= S_BR;
            C_JU:    state <= S_JU;
            default: state <= S_EX;
          endcase
        end
        S_EX: begin
          if ((cls == C_LW) || (cls == C_SW)) begin
            state   <= S_MEM;
            mem_cnt <= 4'd0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_last_s) begin
            state <= S_WB;
          end else begin
            mem_cnt <= mem_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Phase enables are a pure decode of the registered state.
  always_comb begin
    IF  = (state == S_IF);
    ID  = (state == S_ID);
    EX  = (state == S_EX);
    MEM = (state == S_MEM);
    WB  = (state == S_WB);
    BR  = (state == S_BR);
    JU  = (state == S_JU);
  end

  assign instr_done = final_s;
  assign illegal    = (state == S_ID) && (dec_s == C_ILL);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Directed bench for multicycle_ctrl_seq (MEM_LAT=3, CNT_W=3): every cycle's phases,
// instr_done, illegal, busy and retired are compared against hand-written expectations.
module tb_multicycle_ctrl_seq;

  localparam logic [6:0] P_NO = 7'b0000000;
  localparam logic [6:0] P_IF = 7'b1000000;
  localparam logic [6:0] P_ID = 7'b0100000;
  localparam logic [6:0] P_EX = 7'b0010000;
  localparam logic [6:0] P_ME = 7'b0001000;
  localparam logic [6:0] P_WB = 7'b0000100;
  localparam logic [6:0] P_BR = 7'b0000010;
  localparam logic [6:0] P_JU = 7'b0000001;

  logic       clk;
  logic       rst;
  logic       top_en;
  logic [5:0] opcode;
  logic       IF, ID, EX, MEM, WB, BR, JU;
  logic       instr_done;
  logic       illegal;
  logic [2:0] retired;
  logic       busy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  multicycle_ctrl_seq #(.MEM_LAT(3), .CNT_W(3), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .top_en(top_en), .opcode(opcode),
    .IF(IF), .ID(ID), .EX(EX), .MEM(MEM), .WB(WB), .BR(BR), .JU(JU),
    .instr_done(instr_done), .illegal(illegal), .retired(retired), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and compare {phases, instr_done, illegal, busy, retired}.
  task automatic cyc(input string tag, input logic [6:0] ph, input logic done,
                     input logic ill, input logic [2:0] ret);
    logic [12:0] obs;
    logic [12:0] exp;
    @(posedge clk);
    #1;
    obs = {IF, ID, EX, MEM, WB, BR, JU, instr_done, illegal, busy, retired};
    exp = {ph, done, ill, (ph != 7'd0), ret};
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b (IF ID EX MEM WB BR JU done ill busy ret)",
                tag, obs, exp);
  endtask

  initial begin
    rst    = 1'b1;
    top_en = 1'b0;
    opcode = 6'b000000;

    // reset and idle
    cyc("rst0", P_NO, 1'b0, 1'b0, 3'd0);
    cyc("rst1", P_NO, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("idle%0d", i), P_NO, 1'b0, 1'b0, 3'd0);

    // R-type stream, back to back
    top_en = 1'b1;
    opcode = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("r%0d_if", k), P_IF, 1'b0, 1'b0, 3'(k));
      cyc($sformatf("r%0d_id", k), P_ID, 1'b0, 1'b0, 3'(k));
      cyc($sformatf("r%0d_ex", k), P_EX, 1'b0, 1'b0, 3'(k));
      cyc($sformatf("r%0d_wb", k), P_WB, 1'b1, 1'b0, 3'(k));
    end

    // lw with three MEM cycles
    opcode = 6'b100011;
    cyc("lw_if",   P_IF, 1'b0, 1'b0, 3'd3);
    cyc("lw_id",   P_ID, 1'b0, 1'b0, 3'd3);
    cyc("lw_ex",   P_EX, 1'b0, 1'b0, 3'd3);
    cyc("lw_mem0", P_ME, 1'b0, 1'b0, 3'd3);
    cyc("lw_mem1", P_ME, 1'b0, 1'b0, 3'd3);
    cyc("lw_mem2", P_ME, 1'b0, 1'b0, 3'd3);
    cyc("lw_wb",   P_WB, 1'b1, 1'b0, 3'd3);

    // sw finishes on its last MEM cycle
    opcode = 6'b101011;
    cyc("sw_if",   P_IF, 1'b0, 1'b0, 3'd4);
    cyc("sw_id",   P_ID, 1'b0, 1'b0, 3'd4);
    cyc("sw_ex",   P_EX, 1'b0, 1'b0, 3'd4);
    cyc("sw_mem0", P_ME, 1'b0, 1'b0, 3'd4);
    cyc("sw_mem1", P_ME, 1'b0, 1'b0, 3'd4);
    cyc("sw_mem2", P_ME, 1'b1, 1'b0, 3'd4);

    // beq, j, illegal
    opcode = 6'b000100;
    cyc("beq_if", P_IF, 1'b0, 1'b0, 3'd5);
    cyc("beq_id", P_ID, 1'b0, 1'b0, 3'd5);
    cyc("beq_br", P_BR, 1'b1, 1'b0, 3'd5);
    opcode = 6'b000010;
    cyc("j_if",   P_IF, 1'b0, 1'b0, 3'd6);
    cyc("j_id",   P_ID, 1'b0, 1'b0, 3'd6);
    cyc("j_ju",   P_JU, 1'b1, 1'b0, 3'd6);
    opcode = 6'b111111;
    cyc("ill_if", P_IF, 1'b0, 1'b0, 3'd7);
    top_en = 1'b0;
    cyc("ill_id", P_ID, 1'b1, 1'b1, 3'd7);
    cyc("ill_idle0", P_NO, 1'b0, 1'b0, 3'd0);
    cyc("ill_idle1", P_NO, 1'b0, 1'b0, 3'd0);

    // drain: top_en dropped and opcode changed during EX of lw
    top_en = 1'b1;
    opcode = 6'b100011;
    cyc("dr_if",   P_IF, 1'b0, 1'b0, 3'd0);
    cyc("dr_id",   P_ID, 1'b0, 1'b0, 3'd0);
    cyc("dr_ex",   P_EX, 1'b0, 1'b0, 3'd0);
    top_en = 1'b0;
    opcode = 6'b000100;
    cyc("dr_mem0", P_ME, 1'b0, 1'b0, 3'd0);
    cyc("dr_mem1", P_ME, 1'b0, 1'b0, 3'd0);
    cyc("dr_mem2", P_ME, 1'b0, 1'b0, 3'd0);
    cyc("dr_wb",   P_WB, 1'b1, 1'b0, 3'd0);
    cyc("dr_idle0", P_NO, 1'b0, 1'b0, 3'd1);
    cyc("dr_idle1", P_NO, 1'b0, 1'b0, 3'd1);

    // reset in the middle of sw's MEM phase
    top_en = 1'b1;
    opcode = 6'b101011;
    cyc("rs_if",   P_IF, 1'b0, 1'b0, 3'd1);
    cyc("rs_id",   P_ID, 1'b0, 1'b0, 3'd1);
    cyc("rs_ex",   P_EX, 1'b0, 1'b0, 3'd1);
    cyc("rs_mem0", P_ME, 1'b0, 1'b0, 3'd1);
    rst = 1'b1;
    cyc("rs_rst",  P_NO, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;

    // counter wrap over nine R-type instructions
    opcode = 6'b000000;
    for (int k = 0; k < 9; k++) begin
      cyc($sformatf("w%0d_if", k), P_IF, 1'b0, 1'b0, 3'(k));
      cyc($sformatf("w%0d_id", k), P_ID, 1'b0, 1'b0, 3'(k));
      cyc($sformatf("w%0d_ex", k), P_EX, 1'b0, 1'b0, 3'(k));
      if (k == 8) top_en = 1'b0;
      cyc($sformatf("w%0d_wb", k), P_WB, 1'b1, 1'b0, 3'(k));
    end
    cyc("w_idle", P_NO, 1'b0, 1'b0, 3'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
